// File: rtl/waveform_pop_sequencer.sv
// rtl/waveform_pop_sequencer.sv - paced pop strobe and sample capture for the waveform BRAM buffer
module waveform_pop_sequencer #(
   parameter int PERIOD_W = 16,
   parameter int ADDR_W   = 10
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic                loop_mode_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                rd_rewind_o,
   output logic                pop_strobe_o,
   input  logic [31:0]         wave_in_i,
   output logic [31:0]         sample_out_o,
   output logic                sample_valid_o,
   input  logic                sample_ready_i,
   output logic [ADDR_W-1:0]   word_index_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [15:0]         overrun_count_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REWIND = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [ADDR_W-1:0]   pop_idx_q, pop_idx_d;
   logic [15:0]         overrun_q, overrun_d;
   logic                done_q, done_d;

   // read in flight: the BRAM output is valid the cycle after the pop
   logic                rd_pend_q;
   logic [ADDR_W-1:0]   rd_idx_q;

   logic [31:0]         sample_q;
   logic                valid_q;
   logic [ADDR_W-1:0]   word_idx_q;

   logic tick, accept, slot_free, pop, drop, last_pop, drain_done;

   assign accept     = valid_q && sample_ready_i;
   assign tick       = (state_q == ST_RUN) && (tick_cnt_q == '0);
   // a slot being drained this cycle can take the next word, since capture lands two edges later
   assign slot_free  = !valid_q || accept;
   assign pop        = tick && slot_free && !stop_i;
   assign drop       = tick && !slot_free && !stop_i;
   assign last_pop   = pop && (pop_idx_q == {ADDR_W{1'b1}});
   assign drain_done = (state_q == ST_DRAIN) && !rd_pend_q && accept;

   // sequencing: frame start, tick pacing, pop index, drop accounting, frame end
   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      tick_cnt_d = tick_cnt_q;
      pop_idx_d  = pop_idx_q;
      overrun_d  = overrun_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i) begin
               state_d   = ST_REWIND;
               period_d  = (period_i == '0) ? {{(PERIOD_W-1){1'b0}}, 1'b1} : period_i;
               pop_idx_d = '0;
               overrun_d = '0;
            end
         end
         ST_REWIND: begin
            state_d    = ST_RUN;
            tick_cnt_d = '0;
         end
         ST_RUN: begin
            // ticks stay on the period grid whether or not the pop is taken
            tick_cnt_d = tick ? (period_q - 1'b1) : (tick_cnt_q - 1'b1);
            if (pop) begin
               pop_idx_d = pop_idx_q + 1'b1;
               if (last_pop && !loop_mode_i) begin
                  state_d = ST_DRAIN;
               end
            end
            if (drop && (overrun_q != 16'hFFFF)) begin
               overrun_d = overrun_q + 16'd1;
            end
         end
         ST_DRAIN: begin
            if (drain_done) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (stop_i) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end
   end

   // control registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= ST_IDLE;
         period_q   <= '0;
         tick_cnt_q <= '0;
         pop_idx_q  <= '0;
         overrun_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         tick_cnt_q <= tick_cnt_d;
         pop_idx_q  <= pop_idx_d;
         overrun_q  <= overrun_d;
         done_q     <= done_d;
      end
   end

   // capture path: a new word overrides an accept in the same cycle; stop discards everything
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_pend_q  <= 1'b0;
         rd_idx_q   <= '0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         word_idx_q <= '0;
      end else begin
         rd_pend_q <= pop;
         if (pop) begin
            rd_idx_q <= pop_idx_q;
         end
         if (stop_i) begin
            valid_q <= 1'b0;
         end else if (rd_pend_q) begin
            valid_q    <= 1'b1;
            sample_q   <= wave_in_i;
            word_idx_q <= rd_idx_q;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rd_rewind_o     = (state_q == ST_REWIND);
   assign pop_strobe_o    = pop;
   assign sample_out_o    = sample_q;
   assign sample_valid_o  = valid_q;
   assign word_index_o    = word_idx_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign done_o          = done_q;
   assign overrun_count_o = overrun_q;

endmodule

// File: tb/tb_waveform_pop_sequencer.sv
// tb/tb_waveform_pop_sequencer.sv - scoreboard bench for waveform_pop_sequencer
module tb_waveform_pop_sequencer;

   localparam int NW = 1024;
   localparam int P_IDLE   = 0;
   localparam int P_REWIND = 1;
   localparam int P_RUN    = 2;
   localparam int P_DRAIN  = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_mode = 1'b0;
   logic [15:0] period = 16'd0;
   logic        rd_rewind;
   logic        pop_strobe;
   logic [31:0] wave_in = 32'd0;
   logic [31:0] sample_out;
   logic        sample_valid;
   logic        sample_ready = 1'b1;
   logic [9:0]  word_index;
   logic        busy;
   logic        done;
   logic [15:0] overrun_count;

   logic [31:0] mem [0:NW-1];
   logic [9:0]  bram_addr = 10'd0;

   int n_checks = 0;
   int n_fail = 0;

   int cyc = 0;
   int stall_from = 0;
   int stall_to = -1;
   bit rand_ready = 1'b0;

   int  m_phase = P_IDLE;
   int  m_base = 0;
   int  m_period = 1;
   int  m_idx = 0;
   int  m_over = 0;
   int  m_e = 0;
   bit  m_valid = 1'b0;
   bit  m_cap = 1'b0;
   bit  m_done = 1'b0;
   bit  nxt_done, acc, tick, e_pop;
   int  sbq [$];
   int  acc_count = 0;
   int  done_count = 0;
   int  rew_count = 0;

   waveform_pop_sequencer dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .start_i         (start),
      .stop_i          (stop),
      .loop_mode_i     (loop_mode),
      .period_i        (period),
      .rd_rewind_o     (rd_rewind),
      .pop_strobe_o    (pop_strobe),
      .wave_in_i       (wave_in),
      .sample_out_o    (sample_out),
      .sample_valid_o  (sample_valid),
      .sample_ready_i  (sample_ready),
      .word_index_o    (word_index),
      .busy_o          (busy),
      .done_o          (done),
      .overrun_count_o (overrun_count)
   );

   always #5 clk = ~clk;

   // buffer model: pop is the read enable, data appears after the edge
   always @(posedge clk) begin
      if (rd_rewind) begin
         bram_addr <= 10'd0;
      end else if (pop_strobe) begin
         wave_in   <= mem[bram_addr];
         bram_addr <= bram_addr + 10'd1;
      end
   end

   task automatic chk_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // consumer: stall window, random ready or always ready
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if ((cyc + 1) >= stall_from && (cyc + 1) <= stall_to) sample_ready = 1'b0;
         else if (rand_ready) sample_ready = ($urandom_range(0, 3) != 0);
         else sample_ready = 1'b1;
      end
   end

   // monitor + reference model, evaluated mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            m_phase = P_IDLE;
            m_valid = 1'b0;
            m_cap   = 1'b0;
            m_done  = 1'b0;
            m_over  = 0;
            sbq.delete();
         end else begin
            if (sample_valid && sample_ready) acc_count++;
            if (done) done_count++;
            if (rd_rewind) rew_count++;
            chk_eq("rd_rewind", rd_rewind, m_phase == P_REWIND);
            chk_eq("busy", busy, m_phase != P_IDLE);
            chk_eq("done", done, m_done);
            chk_eq("sample_valid", sample_valid, m_valid);
            chk_eq("overrun_count", overrun_count, m_over);
            acc   = m_valid && sample_ready;
            tick  = (m_phase == P_RUN) && !stop && (((cyc - m_base) % m_period) == 0);
            e_pop = tick && (!m_valid || acc);
            chk_eq("pop_strobe", pop_strobe, e_pop);
            if (acc) begin
               chk_eq("scoreboard_nonempty", sbq.size() > 0, 1);
               if (sbq.size() > 0) begin
                  m_e = sbq.pop_front();
                  chk_eq("word_index", word_index, m_e);
                  chk_eq("sample_out", sample_out, mem[m_e]);
               end
            end
            nxt_done = 1'b0;
            if (stop) begin
               m_phase = P_IDLE;
               m_valid = 1'b0;
               m_cap   = 1'b0;
               sbq.delete();
            end else begin
               if (m_cap) begin
                  if (m_valid && !acc && sbq.size() > 0) void'(sbq.pop_front());
                  m_valid = 1'b1;
               end else if (acc) begin
                  m_valid = 1'b0;
               end
               case (m_phase)
                  P_IDLE: if (start) begin
                     m_phase  = P_REWIND;
                     m_over   = 0;
                     m_period = (period == 16'd0) ? 1 : int'(period);
                     m_idx    = 0;
                  end
                  P_REWIND: begin
                     m_phase = P_RUN;
                     m_base  = cyc + 1;
                  end
                  P_RUN: if (tick) begin
                     if (e_pop) begin
                        sbq.push_back(m_idx);
                        if (m_idx == NW - 1 && !loop_mode) m_phase = P_DRAIN;
                        m_idx = (m_idx + 1) % NW;
                     end else if (m_over < 65535) begin
                        m_over++;
                     end
                  end
                  P_DRAIN: if (!m_cap && acc) begin
                     m_phase  = P_IDLE;
                     nxt_done = 1'b1;
                  end
                  default: m_phase = P_IDLE;
               endcase
               m_cap = e_pop;
            end
            m_done = nxt_done;
         end
      end
   end

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < NW; i++) mem[i] = ramp ? 32'(i) : $urandom;
   endtask

   task automatic do_start(input int p, input bit lm);
      @(posedge clk);
      #1;
      period    = p[15:0];
      loop_mode = lm;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_stop();
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      chk_eq("busy_after_stop", busy, 0);
      chk_eq("valid_after_stop", sample_valid, 0);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk_eq("frame_finished_in_budget", busy, 0);
      @(negedge clk);
      #1;
   endtask

   task automatic check_all_zero();
      chk_eq("rst_rd_rewind", rd_rewind, 0);
      chk_eq("rst_pop_strobe", pop_strobe, 0);
      chk_eq("rst_sample_out", sample_out, 0);
      chk_eq("rst_sample_valid", sample_valid, 0);
      chk_eq("rst_word_index", word_index, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_overrun", overrun_count, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, d0, r0;
      fill_mem(1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero();
      @(negedge clk);
      #2;
      reset_n = 1'b1;

      // one-shot, period 4, ramp data
      a0 = acc_count; d0 = done_count;
      do_start(4, 1'b0);
      wait_idle(6000);
      chk_eq("oneshot_accepts", acc_count - a0, NW);
      chk_eq("oneshot_done_pulses", done_count - d0, 1);
      chk_eq("oneshot_overrun", overrun_count, 0);

      // loop mode, period 1: wraps with no rewind and no done
      fill_mem(1'b0);
      a0 = acc_count; d0 = done_count; r0 = rew_count;
      do_start(1, 1'b1);
      repeat (2100) @(posedge clk);
      do_stop();
      chk_eq("loop_accepts_wrapped", (acc_count - a0) >= 2 * NW, 1);
      chk_eq("loop_rewind_pulses", rew_count - r0, 1);
      chk_eq("loop_done_pulses", done_count - d0, 0);

      // 10-cycle consumer stall at period 2
      fill_mem(1'b0);
      a0 = acc_count; d0 = done_count;
      do_start(2, 1'b0);
      repeat (600) @(posedge clk);
      @(negedge clk);
      #1;
      stall_from = cyc + 1;
      stall_to   = cyc + 10;
      repeat (14) @(posedge clk);
      #1;
      chk_eq("stall_overrun", overrun_count, 5);
      wait_idle(6000);
      chk_eq("stall_accepts", acc_count - a0, NW);
      chk_eq("stall_done_pulses", done_count - d0, 1);
      chk_eq("stall_overrun_final", overrun_count, 5);

      // stop mid-frame under random ready, then restart
      fill_mem(1'b0);
      d0 = done_count;
      rand_ready = 1'b1;
      do_start(3, 1'b0);
      repeat (500) @(posedge clk);
      do_stop();
      rand_ready = 1'b0;
      repeat (3) @(posedge clk);
      chk_eq("stop_no_done", done_count - d0, 0);
      a0 = acc_count; d0 = done_count;
      do_start(1, 1'b0);
      wait_idle(3000);
      chk_eq("restart_accepts", acc_count - a0, NW);
      chk_eq("restart_done_pulses", done_count - d0, 1);
      chk_eq("restart_overrun", overrun_count, 0);

      // asynchronous reset between edges mid-run, then a clean frame
      fill_mem(1'b1);
      do_start(4, 1'b0);
      repeat (300) @(posedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      a0 = acc_count; d0 = done_count;
      do_start(4, 1'b0);
      wait_idle(6000);
      chk_eq("postreset_accepts", acc_count - a0, NW);
      chk_eq("postreset_done_pulses", done_count - d0, 1);
      chk_eq("postreset_overrun", overrun_count, 0);

      // random periods (0 included) with a random consumer
      rand_ready = 1'b1;
      for (int it = 0; it < 3; it++) begin
         fill_mem(1'b0);
         d0 = done_count;
         do_start($urandom_range(0, 3), 1'b0);
         wait_idle(30000);
         chk_eq("random_done_pulses", done_count - d0, 1);
      end
      rand_ready = 1'b0;

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
